// File: rtl/vit_pkg.sv
// Shared types and constants for the Viterbi symbol-pipe sequencer and its delay pipe.
package vit_pkg;

  localparam int VIT_SYM_W      = 2;
  localparam int VIT_PIPE_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    PAD   = 3'd3,
    DRAIN = 3'd4
  } vit_state_e;

endpackage

// File: rtl/vit_mark_shreg.sv
// Valid/last shadow marks shifted in lockstep with the symbol delay pipe.
module vit_mark_shreg
  import vit_pkg::*;
#(
  parameter int DEPTH = VIT_PIPE_DEPTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_last  <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], i_valid};
      r_last  <= {r_last[DEPTH-2:0], i_last};
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/vit_pipe_seq_ctrl.sv
// Sequencer for the Viterbi 2-bit symbol delay pipe: framing, pipe clear, shadow marks, drain.
// Zero-tail padding is compiled in with VIT_TAIL_PAD_EN.
//   state | meaning
//   IDLE  | waiting for frame_start
//   CLR   | one-cycle clear of pipe, shadow marks and symbol count
//   RUN   | accepting symbols
//   PAD   | injecting TAIL_LEN zero tail symbols (VIT_TAIL_PAD_EN only)
//   DRAIN | waiting for the last mark to reach the pipe output
module vit_pipe_seq_ctrl
  import vit_pkg::*;
#(
  parameter int DEPTH = VIT_PIPE_DEPTH,
  parameter int SYM_W = VIT_SYM_W,
  parameter int CNT_W = 16
`ifdef VIT_TAIL_PAD_EN
  ,
  parameter int TAIL_LEN = 2
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_last,
  output logic             in_ready,
  output logic             pipe_clr,
  output logic [SYM_W-1:0] pipe_in,
  input  logic [SYM_W-1:0] pipe_out,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] sym_count,
  output logic             proto_err
);

  vit_state_e       r_state;
  vit_state_e       w_state_nxt;
  vit_state_e       w_last_tgt;
  logic             w_accept;
  logic             w_pad_active;
  logic             w_pad_last;
  logic             w_last_marks;
  logic             w_mark_valid;
  logic             w_mark_last;
  logic             w_sh_clr;
  logic [CNT_W-1:0] r_sym_count;
  logic             r_proto_err;

`ifdef VIT_TAIL_PAD_EN
  localparam int PAD_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  logic [PAD_W-1:0] r_pad_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_cnt <= '0;
    end else if (r_state != PAD) begin
      r_pad_cnt <= PAD_W'(TAIL_LEN - 1);
    end else if (r_pad_cnt != '0) begin
      r_pad_cnt <= r_pad_cnt - 1'b1;
    end
  end

  // The real last symbol is left unmarked; the final pad symbol carries the mark.
  assign w_pad_active = (r_state == PAD);
  assign w_pad_last   = w_pad_active && (r_pad_cnt == '0);
  assign w_last_tgt   = PAD;
  assign w_last_marks = 1'b0;
`else
  assign w_pad_active = 1'b0;
  assign w_pad_last   = 1'b0;
  assign w_last_tgt   = DRAIN;
  assign w_last_marks = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (frame_start) w_state_nxt = CLR;
      CLR:     w_state_nxt = RUN;
      RUN:     if (w_accept && in_last) w_state_nxt = w_last_tgt;
      PAD:     if (w_pad_last) w_state_nxt = DRAIN;
      DRAIN:   if (frame_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    pipe_clr = ~reset_n;
    w_sh_clr = 1'b0;
    busy     = (r_state != IDLE);
    case (r_state)
      CLR: begin
        pipe_clr = 1'b1;
        w_sh_clr = 1'b1;
      end
      RUN:     in_ready = 1'b1;
      default: ;
    endcase
  end

  assign w_accept     = in_valid & in_ready;
  assign pipe_in      = w_accept ? in_sym : '0;
  assign w_mark_valid = w_accept | w_pad_active;
  assign w_mark_last  = (w_accept & in_last & w_last_marks) | w_pad_last;

  vit_mark_shreg #(
    .DEPTH (DEPTH)
  ) u_mark_shreg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_sh_clr),
    .i_valid (w_mark_valid),
    .i_last  (w_mark_last),
    .o_valid (out_valid),
    .o_last  (out_last)
  );

  assign out_sym    = pipe_out;
  assign frame_done = out_valid & out_last & (r_state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sym_count <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == CLR) begin
        r_sym_count <= '0;
      end else if (w_accept && (r_sym_count != '1)) begin
        r_sym_count <= r_sym_count + 1'b1;
      end
      // frame_start coinciding with frame_done lands here too, since the state is still DRAIN.
      if ((frame_start && (r_state != IDLE)) ||
          (in_valid && ((r_state == IDLE) || (r_state == CLR)))) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign sym_count = r_sym_count;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_vit_pipe_seq_ctrl.sv
// Bench for vit_pipe_seq_ctrl: behavioural delay pipe plus a cycle-indexed expectation ring.
module tb_vit_pipe_seq_ctrl;

  localparam int DEPTH = 32;
  localparam int RING  = 64;
`ifdef VIT_TAIL_PAD_EN
  localparam int TB_PAD = 2;
`else
  localparam int TB_PAD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_sym = 2'b00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        pipe_clr;
  logic [1:0]  pipe_in;
  logic [1:0]  pipe_out;
  logic        out_valid;
  logic [1:0]  out_sym;
  logic        out_last;
  logic        frame_done;
  logic        busy;
  logic [15:0] sym_count;
  logic        proto_err;

  vit_pipe_seq_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_sym      (in_sym),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .pipe_clr    (pipe_clr),
    .pipe_in     (pipe_in),
    .pipe_out    (pipe_out),
    .out_valid   (out_valid),
    .out_sym     (out_sym),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .busy        (busy),
    .sym_count   (sym_count),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Attached delay pipe: shifts every clock, synchronous active-high clear.
  logic [1:0] pipe_q [DEPTH];
  always @(posedge clk) begin
    if (pipe_clr) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= 2'b00;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign pipe_out = pipe_q[DEPTH-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // What the output side should show in each absolute cycle.
  logic       ev [RING];
  logic       el [RING];
  logic [1:0] es [RING];
  int         mon_idx;

  task automatic ring_clear();
    for (int i = 0; i < RING; i++) begin
      ev[i] = 1'b0;
      el[i] = 1'b0;
      es[i] = 2'b00;
    end
  endtask

  task automatic push_exp(input int c, input logic [1:0] s, input logic last);
    ev[c % RING] = 1'b1;
    es[c % RING] = s;
    el[c % RING] = last;
  endtask

  always @(negedge clk) begin
    #2;
    mon_idx = cyc % RING;
    chk_eq("out_valid", out_valid, ev[mon_idx]);
    if (ev[mon_idx]) chk_eq("out_sym", out_sym, es[mon_idx]);
    chk_eq("out_last", out_last, el[mon_idx]);
    chk_eq("frame_done", frame_done, el[mon_idx]);
    ev[mon_idx] = 1'b0;
    el[mon_idx] = 1'b0;
  end

  typedef struct packed {
    bit         v;
    logic [1:0] s;
    bit         fs;
  } plan_t;

  plan_t plan[$];
  int    m_cnt      = 0;
  bit    m_perr     = 1'b0;
  int    m_last_acc = 0;
  int    m_done_cyc = 0;

  task automatic plan_add(input bit v, input logic [1:0] s);
    plan.push_back('{v: v, s: s, fs: 1'b0});
  endtask

  task automatic plan_random(input int n, input int fs_idx);
    plan.delete();
    for (int i = 0; i < n; i++)
      plan.push_back('{v: (i == n - 1) || ($urandom_range(99) < 70),
                       s: 2'($urandom_range(3)), fs: (i == fs_idx)});
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset_n = 1'b0;
    frame_start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    ring_clear();
    m_perr = 1'b0;
    m_cnt  = 0;
    chk_eq("rst_pipe_clr", pipe_clr, 1'b1);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_in_ready", in_ready, 1'b0);
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_out_last", out_last, 1'b0);
    chk_eq("rst_frame_done", frame_done, 1'b0);
    chk_eq("rst_sym_count", sym_count, 16'd0);
    chk_eq("rst_proto_err", proto_err, 1'b0);
    repeat (ncyc - 1) begin
      @(negedge clk);
      chk_eq("rst_pipe_clr_hold", pipe_clr, 1'b1);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_frame(input bit v_in_clr);
    @(negedge clk);
    chk_eq("idle_in_ready", in_ready, 1'b0);
    chk_eq("idle_busy", busy, 1'b0);
    frame_start = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    frame_start = 1'b0;
    chk_eq("clr_busy", busy, 1'b1);
    chk_eq("clr_pipe_clr", pipe_clr, 1'b1);
    chk_eq("clr_in_ready", in_ready, 1'b0);
    if (v_in_clr) begin
      in_valid = 1'b1;
      in_sym = 2'($urandom_range(1, 3));
      m_perr = 1'b1;
      #1;
      chk_eq("clr_pipe_in", pipe_in, 2'b00);
    end
  endtask

  task automatic drive_plan();
    int lv;
    lv = plan.size() - 1;
    for (int i = 0; i <= lv; i++) begin
      @(negedge clk);
      chk_eq("run_in_ready", in_ready, 1'b1);
      chk_eq("run_pipe_clr", pipe_clr, 1'b0);
      chk_eq("run_sym_count", sym_count, 32'(m_cnt));
      chk_eq("run_proto_err", proto_err, m_perr);
      in_valid = plan[i].v;
      in_sym = plan[i].v ? plan[i].s : 2'($urandom_range(3));
      in_last = (i == lv);
      frame_start = plan[i].fs;
      if (plan[i].fs) m_perr = 1'b1;
      #1;
      chk_eq("run_pipe_in", pipe_in, plan[i].v ? plan[i].s : 2'b00);
      if (plan[i].v) begin
        push_exp(cyc + DEPTH, plan[i].s, (i == lv) && (TB_PAD == 0));
        m_cnt++;
      end
    end
    m_last_acc = cyc;
    for (int p = 1; p <= TB_PAD; p++)
      push_exp(m_last_acc + p + DEPTH, 2'b00, p == TB_PAD);
    m_done_cyc = m_last_acc + TB_PAD + DEPTH;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic finish_frame(input bit collide);
    while (cyc < m_done_cyc) begin
      chk_eq("drain_in_ready", in_ready, 1'b0);
      chk_eq("drain_busy", busy, 1'b1);
      #1;
      chk_eq("drain_pipe_in", pipe_in, 2'b00);
      @(negedge clk);
    end
    chk_eq("done_pulse", frame_done, 1'b1);
    chk_eq("done_sym_count", sym_count, 32'(m_cnt));
    chk_eq("done_busy", busy, 1'b1);
    if (collide) begin
      frame_start = 1'b1;
      m_perr = 1'b1;
    end
    @(negedge clk);
    frame_start = 1'b0;
    chk_eq("post_busy", busy, 1'b0);
    chk_eq("post_proto_err", proto_err, m_perr);
    @(negedge clk);
    chk_eq("post2_busy", busy, 1'b0);
  endtask

  task automatic idle_in_valid();
    @(negedge clk);
    in_valid = 1'b1;
    in_sym = 2'($urandom_range(1, 3));
    m_perr = 1'b1;
    #1;
    chk_eq("idle_pipe_in", pipe_in, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    chk_eq("idle_drop_perr", proto_err, 1'b1);
    chk_eq("idle_drop_count", sym_count, 32'(m_cnt));
    chk_eq("idle_drop_busy", busy, 1'b0);
  endtask

  initial begin
    ring_clear();

    // Reset, then a long idle stretch.
    do_reset(3);
    repeat (40) begin
      @(negedge clk);
      chk_eq("idle40_busy", busy, 1'b0);
    end

    // Basic back-to-back frame 1,2,3,0,1.
    plan.delete();
    plan_add(1, 2'd1); plan_add(1, 2'd2); plan_add(1, 2'd3); plan_add(1, 2'd0); plan_add(1, 2'd1);
    start_frame(0); drive_plan(); finish_frame(0);

    // Bubbles: 3,-,2,-,1.
    plan.delete();
    plan_add(1, 2'd3); plan_add(0, 2'd0); plan_add(1, 2'd2); plan_add(0, 2'd0); plan_add(1, 2'd1);
    start_frame(0); drive_plan(); finish_frame(0);

    // Single-symbol frame.
    plan.delete();
    plan_add(1, 2'd2);
    start_frame(0); drive_plan(); finish_frame(0);

    // frame_start during RUN, then in_valid in IDLE; error stays sticky.
    plan_random(6, 2);
    start_frame(0); drive_plan(); finish_frame(0);
    idle_in_valid();

    // in_valid during CLR, and frame_start colliding with frame_done.
    do_reset(2);
    plan_random(4, -1);
    start_frame(1); drive_plan(); finish_frame(1);

    // Reset 10 cycles into DRAIN: the frame is abandoned silently.
    do_reset(2);
    plan_random(8, -1);
    start_frame(0); drive_plan();
    repeat (10) @(negedge clk);
    do_reset(2);
    repeat (45) begin
      @(negedge clk);
      chk_eq("abort_busy", busy, 1'b0);
    end
    plan.delete();
    plan_add(1, 2'd1); plan_add(1, 2'd2); plan_add(1, 2'd3); plan_add(1, 2'd0); plan_add(1, 2'd1);
    start_frame(0); drive_plan(); finish_frame(0);

    // Randomized frames with idle gaps.
    for (int f = 0; f < 8; f++) begin
      plan_random($urandom_range(1, 14), -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(0); drive_plan(); finish_frame(0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
